// File: rtl/frame_bit_tx.sv
// frame_bit_tx: frames a valid/ready bit-serial payload as SYNC word + payload + CRC-16/CCITT, MSB first.
// Define FRAME_SCRAMBLE_EN to add an additive x^7+x^4+1 payload scrambler (sync and CRC stay clear).
module frame_bit_tx #(
    parameter int unsigned PAYLOAD_BITS = 1976,
    parameter int unsigned SYNC_LEN     = 32,
    parameter logic [63:0] SYNC_WORD    = 64'h0000_0000_1ACF_FC1D,
    parameter logic [15:0] CRC_INIT     = 16'hFFFF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_data,
    input  logic i_valid,
    output logic o_ready,
    output logic o_data,
    output logic o_valid,
    input  logic i_ready,
    output logic o_sof,
    output logic o_eof,
    output logic o_busy
);
    localparam int SW = $clog2(SYNC_LEN + 1);
    localparam int PW = $clog2(PAYLOAD_BITS + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SYNC    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CRC     = 2'd3;

    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
    localparam logic [PW-1:0] PAY_LAST  = PW'(PAYLOAD_BITS - 1);
    localparam logic [5:0]    SYNC_TOP  = 6'(SYNC_LEN - 1);

    logic [1:0]    r_state;
    logic [SW-1:0] r_sync_cnt;
    logic [PW-1:0] r_pay_cnt;
    logic [3:0]    r_crc_cnt;
    logic [15:0]   r_crc;
    logic          r_data;
    logic          r_valid;
    logic          r_sof;
    logic          r_eof;

    logic          w_load;
    logic          w_sync_send;
    logic          w_sync_entry;
    logic [SW-1:0] w_sync_cnt;
    logic [5:0]    w_sync_idx;
    logic          w_crc_fb;
    logic [15:0]   w_crc_next;
    logic          w_pay_bit;

    assign w_load  = !r_valid || i_ready;
    assign o_ready = (r_state == ST_PAYLOAD) && w_load;
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_sof   = r_sof;
    assign o_eof   = r_eof;
    assign o_busy  = (r_state != ST_IDLE);

    // IDLE with data waiting acts as sync position 0, so the first sync bit loads on the frame-start edge.
    assign w_sync_send  = (r_state == ST_SYNC) || ((r_state == ST_IDLE) && i_valid);
    assign w_sync_cnt   = (r_state == ST_SYNC) ? r_sync_cnt : '0;
    assign w_sync_idx   = SYNC_TOP - 6'(w_sync_cnt);
    assign w_sync_entry = ((r_state == ST_IDLE) && i_valid) ||
                          ((r_state == ST_CRC) && w_load && (r_crc_cnt == 4'd15) && i_valid);

    assign w_crc_fb   = r_crc[15] ^ i_data;
    assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);

`ifdef FRAME_SCRAMBLE_EN
    logic [6:0] r_lfsr;

    assign w_pay_bit = i_data ^ r_lfsr[6];

    always_ff @(posedge i_clk) begin
        if (i_reset || w_sync_entry) begin
            r_lfsr <= 7'h7F;
        end else if (i_valid && o_ready) begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[3]};
        end
    end
`else
    assign w_pay_bit = i_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_sync_cnt <= '0;
            r_pay_cnt  <= '0;
            r_crc_cnt  <= '0;
            r_crc      <= CRC_INIT;
            r_data     <= 1'b0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else begin
            // NOTE: non-blocking only; where two branches assign the same register, the later one wins.
            case (r_state)
                ST_IDLE, ST_SYNC: begin
                    if ((r_state == ST_IDLE) && i_valid) begin
                        r_state    <= ST_SYNC;
                        r_sync_cnt <= '0;
                    end
                    if (w_load) begin
                        r_valid <= w_sync_send;
                        r_data  <= w_sync_send && SYNC_WORD[w_sync_idx];
                        r_sof   <= w_sync_send && (w_sync_cnt == '0);
                        r_eof   <= 1'b0;
                        if (w_sync_send) begin
                            if (w_sync_cnt == SYNC_LAST) begin
                                r_state   <= ST_PAYLOAD;
                                r_pay_cnt <= '0;
                            end else begin
                                r_sync_cnt <= w_sync_cnt + SW'(1);
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_load) begin
                        r_valid <= i_valid;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b0;
                        if (i_valid) begin
                            r_data <= w_pay_bit;
                            r_crc  <= w_crc_next;
                            if (r_pay_cnt == PAY_LAST) begin
                                r_state   <= ST_CRC;
                                r_crc_cnt <= '0;
                            end else begin
                                r_pay_cnt <= r_pay_cnt + PW'(1);
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (w_load) begin
                        r_valid   <= 1'b1;
                        r_data    <= r_crc[15];
                        r_crc     <= {r_crc[14:0], 1'b0};
                        r_sof     <= 1'b0;
                        r_eof     <= (r_crc_cnt == 4'd15);
                        r_crc_cnt <= r_crc_cnt + 4'd1;
                        if (r_crc_cnt == 4'd15) begin
                            if (i_valid) begin
                                r_state    <= ST_SYNC;
                                r_sync_cnt <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_sync_entry) begin
                r_crc <= CRC_INIT;
            end
        end
    end
endmodule

// File: tb/tb_frame_bit_tx.sv
// Directed bench for frame_bit_tx: a 72-bit-payload instance for the short tests, a default instance
// for full-length frames. Expected streams come from hand constants plus a small bit-level frame model.
module tb_frame_bit_tx;
    logic clk     = 1'b0;
    logic t_reset = 1'b1;
    logic t_data  = 1'b0;
    logic t_valid = 1'b0;
    logic t_ready = 1'b1;
    logic sel     = 1'b0;

    logic s_ready, s_data, s_valid, s_sof, s_eof, s_busy;
    logic d_ready, d_data, d_valid, d_sof, d_eof, d_busy;
    logic w_ready, w_data, w_valid, w_sof, w_eof, w_busy;

    always #5 clk = ~clk;

    frame_bit_tx #(.PAYLOAD_BITS(72)) u_dut_s (
        .i_clk(clk), .i_reset(t_reset), .i_data(t_data), .i_valid(t_valid & ~sel),
        .o_ready(s_ready), .o_data(s_data), .o_valid(s_valid), .i_ready(t_ready),
        .o_sof(s_sof), .o_eof(s_eof), .o_busy(s_busy)
    );

    frame_bit_tx u_dut_d (
        .i_clk(clk), .i_reset(t_reset), .i_data(t_data), .i_valid(t_valid & sel),
        .o_ready(d_ready), .o_data(d_data), .o_valid(d_valid), .i_ready(t_ready),
        .o_sof(d_sof), .o_eof(d_eof), .o_busy(d_busy)
    );

    assign w_ready = sel ? d_ready : s_ready;
    assign w_data  = sel ? d_data  : s_data;
    assign w_valid = sel ? d_valid : s_valid;
    assign w_sof   = sel ? d_sof   : s_sof;
    assign w_eof   = sel ? d_eof   : s_eof;
    assign w_busy  = sel ? d_busy  : s_busy;

    int n_vec = 0;
    int n_err = 0;

    bit pay_bits [0:4095];
    bit exp_q [$];
    bit out_bits [$];
    int sof_idx [$];
    int eof_idx [$];
    int flen, acc, cyc, vis_err, invalid_mid, stalls, first_valid;
    logic busy_mid;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic void fill(input int seed);
        for (int i = 0; i < 4096; i++) pay_bits[12'(i)] = (((i * 37 + seed) % 7) < 3);
    endfunction

    function automatic void load_ascii();
        logic [71:0] v;
        v = 72'h31_32_33_34_35_36_37_38_39;
        for (int i = 0; i < 72; i++) begin
            pay_bits[12'(i)] = v[71];
            v = v << 1;
        end
    endfunction

    function automatic void build_exp(input int n_pay, input int n_frames);
        logic [31:0] sync;
        logic [15:0] crc;
        bit b;
`ifdef FRAME_SCRAMBLE_EN
        logic [6:0] lfsr;
`endif
        exp_q.delete();
        flen = 48 + n_pay;
        for (int f = 0; f < n_frames; f++) begin
            sync = 32'h1ACFFC1D;
            crc  = 16'hFFFF;
`ifdef FRAME_SCRAMBLE_EN
            lfsr = 7'h7F;
`endif
            for (int i = 0; i < 32; i++) begin
                exp_q.push_back(sync[31]);
                sync = sync << 1;
            end
            for (int i = 0; i < n_pay; i++) begin
                b   = pay_bits[12'(f * n_pay + i)];
                crc = crc_step(crc, b);
`ifdef FRAME_SCRAMBLE_EN
                b    = b ^ lfsr[6];
                lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[3]};
`endif
                exp_q.push_back(b);
            end
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(crc[15]);
                crc = crc << 1;
            end
        end
    endfunction

    function automatic logic [79:0] field(input int start, input int len);
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < len; i++)
            v = {v[78:0], (start + i < out_bits.size()) ? out_bits[start + i] : 1'b0};
        return v;
    endfunction

    function automatic int stream_miss();
        int m;
        m = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= out_bits.size() || out_bits[i] != exp_q[i]) m++;
        return m;
    endfunction

    task automatic do_reset();
        t_reset = 1'b1;
        t_valid = 1'b0;
        t_ready = 1'b1;
        t_data  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        t_reset = 1'b0;
    endtask

    // Drives one cycle per negedge and samples 1 time unit later; o_ready settles from t_ready in between.
    task automatic run(input int n_frames, input int ready_mode, input int gap_at,
                       input int stop_at, input int budget, input string tag);
        int gap_left;
        bit gap_done;
        bit done;
        int n;
        gap_left = 0;
        gap_done = 1'b0;
        done     = 1'b0;
        out_bits.delete();
        sof_idx.delete();
        eof_idx.delete();
        acc = 0; cyc = 0; vis_err = 0; invalid_mid = 0; stalls = 0; first_valid = -1;
        busy_mid = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            t_ready = (ready_mode == 1 && acc >= 20 && acc < 60) ? ((cyc / 3) % 2 == 0) : 1'b1;
            if (gap_at >= 0 && acc == gap_at && !gap_done) begin
                gap_left = 10;
                gap_done = 1'b1;
            end
            if (gap_left > 0) begin
                t_valid = 1'b0;
                gap_left--;
            end else begin
                t_valid = 1'b1;
            end
            t_data = pay_bits[12'(acc % 4096)];
            #1;
            if (cyc == 5) busy_mid = w_busy;
            if (w_valid) begin
                n = out_bits.size();
                if (first_valid < 0) first_valid = cyc;
                if (n >= exp_q.size() || w_data !== exp_q[n] ||
                    w_sof !== (n % flen == 0) || w_eof !== (n % flen == flen - 1))
                    vis_err++;
                if (t_ready) begin
                    out_bits.push_back(w_data);
                    if (w_sof) sof_idx.push_back(n);
                    if (w_eof) begin
                        eof_idx.push_back(n);
                        if (eof_idx.size() >= n_frames) done = 1'b1;
                    end
                end else begin
                    stalls++;
                end
            end else if (out_bits.size() > 0) begin
                invalid_mid++;
            end
            if (t_valid && w_ready) begin
                acc++;
                if (stop_at >= 0 && acc >= stop_at) done = 1'b1;
            end
            cyc++;
        end
        check({tag, " done"}, 80'(done), 80'(1));
    endtask

    initial begin
        logic [15:0] zc;

        // Reset state of both instances
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("reset outs dut%0d", s),
                  80'({w_valid, w_busy, w_ready, w_sof, w_eof, w_data}), 80'(0));
        end

        // 1: 72-bit "123456789" frame, sink always ready
        do_reset();
        sel = 1'b0;
        load_ascii();
        build_exp(72, 1);
        run(1, 0, -1, -1, 500, "t1");
        check("t1 latency", 80'(first_valid), 80'(1));
        check("t1 busy", 80'(busy_mid), 80'(1));
        check("t1 length", 80'(out_bits.size()), 80'(120));
        check("t1 sync", field(0, 32), 80'h1ACFFC1D);
`ifndef FRAME_SCRAMBLE_EN
        check("t1 payload", field(32, 72), 80'h31_32_33_34_35_36_37_38_39);
`endif
        check("t1 crc", field(104, 16), 80'h29B1);
        check("t1 sof count", 80'(sof_idx.size()), 80'(1));
        check("t1 eof pos", 80'((eof_idx.size() > 0) ? eof_idx[0] : -1), 80'(119));
        check("t1 stream", 80'(stream_miss()), 80'(0));
        check("t1 per-cycle", 80'(vis_err), 80'(0));

        // 2: two default frames back to back
        do_reset();
        sel = 1'b1;
        fill(3);
        build_exp(1976, 2);
        run(2, 0, -1, -1, 6000, "t2");
        check("t2 length", 80'(out_bits.size()), 80'(4048));
        check("t2 eof1", 80'((eof_idx.size() > 0) ? eof_idx[0] : -1), 80'(2023));
        check("t2 sof2", 80'((sof_idx.size() > 1) ? sof_idx[1] : -1), 80'(2024));
        check("t2 eof2", 80'((eof_idx.size() > 1) ? eof_idx[1] : -1), 80'(4047));
        check("t2 gaps", 80'(invalid_mid), 80'(0));
        check("t2 accepted", 80'(acc), 80'(3952));
        check("t2 stream", 80'(stream_miss()), 80'(0));
        check("t2 per-cycle", 80'(vis_err), 80'(0));

        // 3: sink toggles ready every 3 cycles mid-payload
        do_reset();
        sel = 1'b0;
        load_ascii();
        build_exp(72, 1);
        run(1, 1, -1, -1, 800, "t3");
        check("t3 stalls seen", 80'(stalls > 0), 80'(1));
        check("t3 length", 80'(out_bits.size()), 80'(120));
        check("t3 crc", field(104, 16), 80'h29B1);
        check("t3 stream", 80'(stream_miss()), 80'(0));
        check("t3 per-cycle", 80'(vis_err), 80'(0));

        // 4: source drops valid for 10 cycles at payload bit 500
        do_reset();
        sel = 1'b1;
        fill(5);
        build_exp(1976, 1);
        run(1, 0, 500, -1, 3000, "t4");
        check("t4 drain cycles", 80'(invalid_mid), 80'(10));
        check("t4 accepted", 80'(acc), 80'(1976));
        check("t4 length", 80'(out_bits.size()), 80'(2024));
        check("t4 stream", 80'(stream_miss()), 80'(0));
        check("t4 per-cycle", 80'(vis_err), 80'(0));

        // 5: reset pulse at payload bit 100, then a clean frame
        do_reset();
        sel = 1'b1;
        fill(9);
        build_exp(1976, 1);
        run(1, 0, -1, 100, 1000, "t5a");
        check("t5 busy before reset", 80'(w_busy), 80'(1));
        t_reset = 1'b1;
        @(negedge clk);
        #1;
        check("t5 after reset", 80'({w_valid, w_busy, w_ready, w_sof, w_eof}), 80'(0));
        t_reset = 1'b0;
        t_valid = 1'b0;
        fill(11);
        build_exp(1976, 1);
        run(1, 0, -1, -1, 3000, "t5b");
        check("t5 latency", 80'(first_valid), 80'(1));
        check("t5 sync", field(0, 32), 80'h1ACFFC1D);
        check("t5 stream", 80'(stream_miss()), 80'(0));
        check("t5 per-cycle", 80'(vis_err), 80'(0));

        // 6: all-zero payload exposes the scrambler sequence (or its absence)
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 4096; i++) pay_bits[12'(i)] = 1'b0;
        build_exp(1976, 1);
        run(1, 0, -1, -1, 3000, "t6");
`ifdef FRAME_SCRAMBLE_EN
        check("t6 first7", field(32, 8), 80'hFE);
`else
        check("t6 first7", field(32, 8), 80'h00);
`endif
        zc = 16'hFFFF;
        for (int i = 0; i < 1976; i++) zc = crc_step(zc, 1'b0);
        check("t6 crc of zeros", field(2008, 16), 80'(zc));
        check("t6 stream", 80'(stream_miss()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
